// File: rtl/maxpool_ctrl_pkg.sv
// Shared types and helpers for the max-pooling layer sequencer.
//   state_t     : sequencer states
//   pix_per_ch  : input pixels per channel for a square map of side w
//   out_per_ch  : pooled outputs per channel for a square map of side w
//   cnt_width   : bits needed to hold 0..max_val (never less than 1)
package maxpool_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int unsigned pix_per_ch(input int unsigned w);
    return w * w;
  endfunction

  function automatic int unsigned out_per_ch(input int unsigned w);
    return (w / 2) * (w / 2);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rd_valid_delay.sv
// Delays the input-RAM read strobe by the RAM's fixed read latency so the
// pooling engine sees a valid exactly when the read data arrives.
//   clk, rst : clock, asynchronous active-high clear
//   i_d      : read strobe
//   o_q      : read strobe delayed by DEPTH cycles
module rd_valid_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  // Shift register; clearing it on reset discards reads still in flight.
  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else begin
          r_sr <= i_d;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else begin
          r_sr <= {r_sr[DEPTH-2:0], i_d};
        end
      end
    end
  endgenerate

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/maxpool_layer_ctrl.sv
// Sequences one shared 2x2 max-pooling engine over every channel of a
// feature map: clear engine, stream the channel's pixels from the input RAM,
// wait for all pooled results, write them contiguously to the output RAM.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, in_base, out_base : layer start pulse and map base addresses
//   busy, done, err          : layer status; err is a sticky overrun flag
//   rd_en, rd_addr, rd_data  : input RAM read port (fixed RD_LATENCY)
//   pool_clr, pool_valid,
//   pool_data                : pixel stream into the engine
//   pool_o_valid, pool_o_data: pooled results from the engine
//   wr_en, wr_addr, wr_data  : output RAM write port
module maxpool_layer_ctrl
  import maxpool_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IMAGE_WIDTH = 4,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pool_clr,
  output logic                  pool_valid,
  output logic [DATA_WIDTH-1:0] pool_data,
  input  logic                  pool_o_valid,
  input  logic [DATA_WIDTH-1:0] pool_o_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  err
);

  localparam int unsigned PIX   = pix_per_ch(IMAGE_WIDTH);
  localparam int unsigned OPC   = out_per_ch(IMAGE_WIDTH);
  localparam int unsigned CH_W  = cnt_width(CHANNELS - 1);
  localparam int unsigned PIX_W = cnt_width(PIX - 1);
  localparam int unsigned CO_W  = cnt_width(OPC);
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;

  // Sequencer state and counters
  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_in_base, w_in_base_nxt;
  logic [AW-1:0]   r_out_base, w_out_base_nxt;
  logic [CH_W-1:0] r_ch, w_ch_nxt;
  logic [PIX_W-1:0] r_pix, w_pix_nxt;
  logic [CO_W-1:0] r_ch_out, w_ch_out_nxt;
  logic [AW-1:0]   r_out_idx, w_out_idx_nxt;
  logic            r_err, w_err_nxt;

  // Registered outputs and their next values
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_pool_clr, w_pool_clr_nxt;
  logic            r_rd_en, w_rd_en_nxt;
  logic [AW-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [DW-1:0]   r_wr_data;
  logic            w_wr_fire;

  // Next-state, counter and output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_in_base_nxt  = r_in_base;
    w_out_base_nxt = r_out_base;
    w_ch_nxt       = r_ch;
    w_pix_nxt      = r_pix;
    w_ch_out_nxt   = r_ch_out;
    w_out_idx_nxt  = r_out_idx;
    w_err_nxt      = r_err;
    w_wr_fire      = r_busy & pool_o_valid;
    w_wr_addr_nxt  = r_out_base + r_out_idx;

    // Every result seen while busy is written; one arriving after the
    // channel already holds its full count flags an overrun. ch_out holds
    // at OPC so the drain condition stays true despite the extra result.
    if (w_wr_fire) begin
      w_out_idx_nxt = r_out_idx + AW'(1);
      if (r_ch_out == CO_W'(OPC)) begin
        w_err_nxt = 1'b1;
      end else begin
        w_ch_out_nxt = r_ch_out + CO_W'(1);
      end
    end

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_in_base_nxt  = in_base;
          w_out_base_nxt = out_base;
          w_ch_nxt       = '0;
          w_out_idx_nxt  = '0;
          w_err_nxt      = 1'b0;
          w_state_nxt    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_pix_nxt    = '0;
        w_ch_out_nxt = '0;
        w_state_nxt  = ST_STREAM;
      end
      ST_STREAM: begin
        if (r_pix == PIX_W'(PIX - 1)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_pix_nxt = r_pix + PIX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_ch_out == CO_W'(OPC)) begin
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (r_ch == CH_W'(CHANNELS - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_ch_nxt    = r_ch + CH_W'(1);
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    w_busy_nxt     = (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_STREAM) ||
                     (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_NEXT);
    w_done_nxt     = (w_state_nxt == ST_DONE);
    w_pool_clr_nxt = (w_state_nxt == ST_CLEAR);
    w_rd_en_nxt    = (w_state_nxt == ST_STREAM);
    w_rd_addr_nxt  = w_in_base_nxt + (AW'(w_ch_nxt) * AW'(PIX)) + AW'(w_pix_nxt);
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_base  <= '0;
      r_out_base <= '0;
      r_ch       <= '0;
      r_pix      <= '0;
      r_ch_out   <= '0;
      r_out_idx  <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pool_clr <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_base  <= w_in_base_nxt;
      r_out_base <= w_out_base_nxt;
      r_ch       <= w_ch_nxt;
      r_pix      <= w_pix_nxt;
      r_ch_out   <= w_ch_out_nxt;
      r_out_idx  <= w_out_idx_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pool_clr <= w_pool_clr_nxt;
      r_rd_en    <= w_rd_en_nxt;
      if (w_rd_en_nxt) begin
        r_rd_addr <= w_rd_addr_nxt;
      end
      r_wr_en <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= w_wr_addr_nxt;
        r_wr_data <= pool_o_data;
      end
    end
  end

  // Read-return valid follows rd_en by the RAM latency
  rd_valid_delay #(
    .DEPTH(RD_LATENCY)
  ) u_rd_valid_delay (
    .clk (clk),
    .rst (rst),
    .i_d (r_rd_en),
    .o_q (pool_valid)
  );

  assign pool_data = rd_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign pool_clr  = r_pool_clr;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign err       = r_err;

endmodule
